filtro_ctrl: RTL

//  Sequencer for the filter sample delay line (3-deep x[n], x[n-1], x[n-2] store)
//  and its shared multiply-accumulate path. On each accepted new-sample strobe it:

---
 rtl/filtro_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/filtro_ctrl.sv
// filtro_ctrl: sequencer for the FILTRO sample delay line and shared MAC path.
// Each accepted sample strobe walks LOAD -> MAC (N_TAPS cycles) -> SHIFT -> DONE.
// All outputs are decoded from registered state, so they are glitch-free Moore outputs.
module filtro_ctrl #(
  parameter int N_TAPS = 5,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             muestra_lista,
  input  logic             clr_overrun,
  output logic             leer,
  output logic             desp,
  output logic [SEL_W-1:0] sel,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             dato_listo,
  output logic             ocupado,
  output logic             overrun,
  output logic [CNT_W-1:0] n_muestras
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Index of the final product; N_TAPS never exceeds 2**SEL_W so this fits.
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_TAPS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             strobe_ok;
  logic             strobe_accept;
  logic             strobe_drop;

  // A strobe only counts while enabled; it starts a sequence from IDLE, otherwise it is lost.
  assign strobe_ok     = en && muestra_lista;
  assign strobe_accept = strobe_ok && (state_q == IDLE);
  assign strobe_drop   = strobe_ok && (state_q != IDLE);

  // State register: synchronous active-low reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic: sequencing, tap stepping, sample count and sticky overrun.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (strobe_accept) state_d = LOAD;
      end
      LOAD: begin
        sel_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        if (sel_q == LAST_SEL) begin
          sel_d   = '0;
          state_d = SHIFT;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      SHIFT: begin
        // Count bumps on entry to DONE so n_muestras is current while dato_listo is high.
        sel_d   = '0;
        cnt_d   = cnt_q + 1'b1;
        state_d = DONE;
      end
      DONE: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A lost strobe takes priority over a clear arriving in the same cycle.
    if (strobe_drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Output decode: strobes depend only on the registered state.
  always_comb begin
    leer       = 1'b0;
    desp       = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    dato_listo = 1'b0;
    ocupado    = (state_q != IDLE);
    unique case (state_q)
      IDLE:    ;
      LOAD: begin
        leer    = 1'b1;
        acc_clr = 1'b1;
      end
      MAC:     acc_en     = 1'b1;
      SHIFT:   desp       = 1'b1;
      DONE:    dato_listo = 1'b1;
      default: ;
    endcase
  end

  assign sel        = sel_q;
  assign overrun    = overrun_q;
  assign n_muestras = cnt_q;

endmodule
